// File: rtl/uart_mux_pkg.sv
// uart_mux_pkg: shared types and constants for the line-atomic UART multiplexer.
//   mux_state_e  - arbiter/serialiser FSM states
//   CH_*         - newline and "[k] " tag characters
//   src_width()  - width of a channel index (at least 1 bit)
package uart_mux_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      BODY   = 2'd2
   } mux_state_e;

   localparam logic [7:0] CH_NEWLINE  = 8'h0A;
   localparam logic [7:0] CH_LBRACKET = 8'h5B;
   localparam logic [7:0] CH_RBRACKET = 8'h5D;
   localparam logic [7:0] CH_SPACE    = 8'h20;
   localparam logic [7:0] CH_DIGIT0   = 8'h30;

   function automatic int src_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/uart_line_mux_if.sv
// uart_line_mux_if: merged output character stream (ready/valid).
//   out_valid - character valid
//   out_ch    - character
//   out_src   - channel that produced out_ch
//   out_ready - consumer accepts on out_valid && out_ready
// master = the multiplexer, slave = the console consumer.
interface uart_line_mux_if #(
   parameter int NCH = 4
);
   import uart_mux_pkg::*;

   localparam int SRC_W = src_width(NCH);

   logic             out_valid;
   logic [7:0]       out_ch;
   logic [SRC_W-1:0] out_src;
   logic             out_ready;

   modport master (output out_valid, output out_ch, output out_src, input out_ready);
   modport slave  (input out_valid, input out_ch, input out_src, output out_ready);

endinterface

// File: rtl/uart_line_fifo.sv
// uart_line_fifo: per-channel character FIFO with line bookkeeping.
// Ports:
//   clock, reset_n - clock and synchronous active-low reset
//   push/push_data - incoming character strobe (no backpressure)
//   pop            - remove head character
//   head           - current head character
//   empty          - FIFO holds nothing
//   last_entry     - exactly one entry held and no write this cycle, so a
//                    pop now leaves the FIFO empty
//   overflow       - sticky: a character was dropped because the FIFO was full
//   eligible       - a complete line is held, the FIFO is full, or the
//                    partial line has been idle for TIMEOUT cycles
module uart_line_fifo
   import uart_mux_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       empty,
   output logic       last_entry,
   output logic       overflow,
   output logic       eligible
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

   logic [7:0]    mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   level;
   logic [AW:0]   line_cnt;
   logic [TW-1:0] timer;
   logic          full;
   logic          push_ok;
   logic          pop_ok;
   logic          push_nl;
   logic          pop_nl;

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head    = mem[rd_ptr[AW-1:0]];

   // Fullness is judged on the state at the start of the cycle; a pop in
   // the same cycle does not make room for the write.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign push_nl = push_ok && (push_data == CH_NEWLINE);
   assign pop_nl  = pop_ok && (head == CH_NEWLINE);

   assign last_entry = (level == (AW+1)'(1)) && !push_ok;

   // The timeout term also needs data present: the timer holds its value for
   // the cycle right after the last pop.
   assign eligible = (line_cnt != '0) || full
                     || ((TIMEOUT != 0) && (timer == TIMER_MAX) && !empty);

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         line_cnt <= '0;
         timer    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         if (push && full) begin
            overflow <= 1'b1;
         end
         case ({push_nl, pop_nl})
            2'b10:   line_cnt <= line_cnt + (AW+1)'(1);
            2'b01:   line_cnt <= line_cnt - (AW+1)'(1);
            default: ;
         endcase
         if (push_ok || empty) begin
            timer <= '0;
         end else if (timer != TIMER_MAX) begin
            timer <= timer + TW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_line_mux.sv
// uart_line_mux: collects characters from NCH UART channels, buffers them per
// line and serialises whole lines onto one ready/valid stream so output from
// different cores never interleaves mid-line.
// Ports:
//   clock, reset_n - clock and synchronous active-low reset
//   in_valid[k]    - character strobe of channel k (no backpressure)
//   in_ch          - channel k character in bits [8k+7:8k]
//   overflow[k]    - sticky: channel k dropped a character
//   bus            - merged output stream (uart_line_mux_if.master)
// Build option: define UART_PREFIX_EN to precede every burst with "[k] ".
// Outputs are decoded from registered FSM state and the FIFO head, so they
// stay put while out_valid && !out_ready and allow one character per cycle.
//
// state  | meaning
// IDLE   | no burst; pick next eligible channel round-robin
// PREFIX | emit "[k] " for the granted channel (UART_PREFIX_EN only)
// BODY   | drain granted FIFO until newline popped or FIFO empty
module uart_line_mux
   import uart_mux_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [NCH-1:0]   in_valid,
   input  logic [NCH*8-1:0] in_ch,
   output logic [NCH-1:0]   overflow,
   uart_line_mux_if.master  bus
);

   localparam int SW = src_width(NCH);

   mux_state_e    state;
   mux_state_e    state_n;
   logic [SW-1:0] grant;
   logic [SW-1:0] grant_n;
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] rr_n;
   logic [SW-1:0] rr_after_grant;
   logic [SW-1:0] sel;
   logic [SW-1:0] cand;
   logic          sel_found;
   logic          body_pop;
   logic          out_valid;
   logic [7:0]    out_ch;
   logic [NCH-1:0] eligible;
   logic [NCH-1:0] empty;
   logic [NCH-1:0] last_entry;
   logic [NCH-1:0] pop;
   logic [7:0]     head [NCH];
`ifdef UART_PREFIX_EN
   logic [1:0]    pidx;
   logic [1:0]    pidx_n;
`endif

   function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NCH) begin
         s = s - NCH;
      end
      return SW'(s);
   endfunction

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign pop[k] = body_pop && (grant == SW'(k));

      uart_line_fifo #(
         .DEPTH   (DEPTH),
         .TIMEOUT (TIMEOUT)
      ) u_fifo (
         .clock      (clock),
         .reset_n    (reset_n),
         .push       (in_valid[k]),
         .push_data  (in_ch[8*k +: 8]),
         .pop        (pop[k]),
         .head       (head[k]),
         .empty      (empty[k]),
         .last_entry (last_entry[k]),
         .overflow   (overflow[k]),
         .eligible   (eligible[k])
      );
   end

   assign rr_after_grant = wrap_add(grant, 1);

   // First eligible channel at or after the round-robin pointer.
   always_comb begin
      sel       = '0;
      cand      = '0;
      sel_found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         cand = wrap_add(rr_ptr, i);
         if (!sel_found && eligible[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
`ifdef UART_PREFIX_EN
         pidx   <= '0;
`endif
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         rr_ptr <= rr_n;
`ifdef UART_PREFIX_EN
         pidx   <= pidx_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant;
      rr_n      = rr_ptr;
      body_pop  = 1'b0;
      out_valid = 1'b0;
      out_ch    = '0;
`ifdef UART_PREFIX_EN
      pidx_n    = pidx;
`endif
      case (state)
         IDLE: begin
            if (sel_found) begin
               grant_n = sel;
`ifdef UART_PREFIX_EN
               state_n = PREFIX;
               pidx_n  = '0;
`else
               state_n = BODY;
`endif
            end
         end
`ifdef UART_PREFIX_EN
         PREFIX: begin
            out_valid = 1'b1;
            case (pidx)
               2'd0:    out_ch = CH_LBRACKET;
               2'd1:    out_ch = CH_DIGIT0 + 8'(grant);
               2'd2:    out_ch = CH_RBRACKET;
               default: out_ch = CH_SPACE;
            endcase
            if (bus.out_ready) begin
               pidx_n = pidx + 2'd1;
               if (pidx == 2'd3) begin
                  state_n = BODY;
               end
            end
         end
`endif
         BODY: begin
            if (!empty[grant]) begin
               out_valid = 1'b1;
               out_ch    = head[grant];
               if (bus.out_ready) begin
                  body_pop = 1'b1;
                  if ((head[grant] == CH_NEWLINE) || last_entry[grant]) begin
                     state_n = IDLE;
                     rr_n    = rr_after_grant;
                  end
               end
            end else begin
               // Nothing left to send; release the channel.
               state_n = IDLE;
               rr_n    = rr_after_grant;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.out_valid = out_valid;
   assign bus.out_ch    = out_ch;
   assign bus.out_src   = out_valid ? grant : '0;

endmodule

// File: doc/uart_line_mux.md
Name: uart_line_mux

Overview:
- Parametrised successor to the single-channel simulation UART sink.
- Captures console characters from NCH independent UART output ports (one per hart/core), buffers each channel per line, and serialises whole lines onto one ready/valid character stream.
- The testbench drains that stream into the host console DPI, so output from multiple cores never interleaves mid-line.

Parameters:
- NCH, 4, number of input channels (1..10).
- DEPTH, 64, per-channel FIFO entries; power of two, >= 4.
- TIMEOUT, 1024, idle cycles after which a channel holding a partial line becomes eligible to flush; 0 disables.

Ports:
- clock  input  1  sole clock.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- in_valid  input  NCH  per-channel character strobe; no backpressure.
- in_ch  input  NCH*8  per-channel character; channel k occupies bits [8k+7:8k].
- out_valid  output  1  output character valid.
- out_ch  output  8  output character.
- out_src  output  max(1,$clog2(NCH))  channel that produced out_ch.
- out_ready  input  1  consumer accepts out_ch when out_valid && out_ready.
- overflow  output  NCH  sticky per-channel flag: a character was dropped.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - FIFOs empty; line counters, idle timers and overflow cleared.
  - FSM to IDLE; round-robin pointer = 0.
  - out_valid=0, out_ch=0, out_src=0.
  - Reset mid-line discards all buffered data with no partial flush.
- Push:
  - in_valid[k] with FIFO k not full at the start of the cycle: write the character.
  - FIFO full: drop the character and set overflow[k].
  - A pop in the same cycle does not create room (no bypass).
- Per-channel line count:
  - +1 on push of 8'h0A; -1 on pop of 8'h0A.
  - Simultaneous push and pop of 8'h0A leaves it unchanged.
- Idle timer:
  - Cleared on every push.
  - Counts while the FIFO is non-empty; saturates at TIMEOUT.
- Eligible(k): line count > 0, OR FIFO full, OR (TIMEOUT != 0 and timer == TIMEOUT).
- FSM IDLE:
  - Pick the first eligible channel starting at the round-robin pointer (wrapping NCH-1 -> 0).
  - Latch it as grant; go to PREFIX if enabled, else BODY.
  - No eligible channel: stay in IDLE with out_valid=0.
- FSM PREFIX: emit 4 characters '[', ASCII digit of grant, ']', ' ' in order, each held until accepted; then go to BODY.
- FSM BODY:
  - out_ch = head of FIFO[grant]; out_valid = FIFO non-empty.
  - On handshake, pop.
  - Leave BODY when the popped character is 8'h0A, or the FIFO is empty after the pop.
  - On leaving: pointer = grant+1 mod NCH; return to IDLE.
- Output registers:
  - out_valid/out_ch/out_src are held stable while out_valid && !out_ready.
  - First character appears 1 cycle after the IDLE grant decision.
  - Sustained throughput is 1 char/cycle with out_ready=1.
- Characters pushed to the granted channel during BODY are drained in the same burst until 8'h0A or empty.
- Line count never exceeds DEPTH; counter width is $clog2(DEPTH)+1.

Optional Feature:
- UART_PREFIX_EN defined: PREFIX state present; every burst is preceded by the "[k] " tag.
- UART_PREFIX_EN undefined: PREFIX state removed; IDLE goes directly to BODY; output is raw line-atomic text.

Decomposition:
- Package uart_mux_pkg:
  - FSM state enum (IDLE, PREFIX, BODY).
  - CH_NEWLINE = 8'h0A.
  - Prefix character constants '[', ']', ' ', and ASCII '0' base.
- Sub-module uart_line_fifo, instantiated NCH times:
  - Circular FIFO with wrap-bit pointers.
  - Line counter, idle timer, overflow flag, and the eligible output.
- Top level contains the arbiter and FSM.

Test Plan:
- Single line: push "hi\n" on ch2, out_ready=1 -> stream "[2] hi\n" (with prefix) with out_src=2; overflow=0.
- Interleaved inputs: ch0 pushes "ab\n" and ch1 pushes "cd\n" on alternating cycles -> output "[0] ab\n[1] cd\n"; no character mixing.
- Round-robin: ch0 and ch3 each hold two complete lines, pointer=0 -> order ch0, ch3, ch0, ch3.
- Overflow: DEPTH=4, push "abcdef" on ch1 with no newline and out_ready=0 -> "abcd" kept; overflow[1]=1.
  - Raise out_ready -> "[1] abcd" flushed via the full condition; overflow stays 1 until reset.
- Timeout: TIMEOUT=16, push "x" on ch0, then idle -> 16 cycles after the push the channel becomes eligible and "[0] x" is emitted with no newline.
- Backpressure and reset: toggle out_ready randomly during "[3] hello\n" -> out_ch stable while stalled, exact sequence delivered.
  - reset_n=0 mid-burst -> out_valid=0 next cycle; FIFOs empty.
